// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared video definitions: pixel level codes, the default line length and
// the life-cycle states of a line bank.
// Level codes are {out_450ohm, out_900ohm}.
// ----------------------------------------------------------------------------
package video_pkg;

  localparam int PIXELS_PER_LINE = 256;

  localparam logic [1:0] LEVEL_SYNC  = 2'b00;
  localparam logic [1:0] LEVEL_BLACK = 2'b01;
  localparam logic [1:0] LEVEL_WHITE = 2'b11;

  // A bank cycles EMPTY -> FILLING -> FULL -> READING -> EMPTY.
  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_e;

endpackage

// File: rtl/line_bank_ram.sv
// ----------------------------------------------------------------------------
// line_bank_ram
// Simple dual-port storage for both line banks: one write port, one read
// port with a registered output (one cycle read latency).
// Ports:
//   clk      - clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address, sampled every cycle
//   o_rdata  - read data, valid the cycle after i_raddr
// ----------------------------------------------------------------------------
module line_bank_ram #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array and its read register have no reset so the storage maps
  // onto block RAM; stale contents are never seen because bank lengths gate
  // every read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_pingpong_buffer.sv
// ----------------------------------------------------------------------------
// line_pingpong_buffer
// Two-bank scanline buffer between a pixel producer and the video timing
// generator. One bank fills while the other is rendered; banks swap on each
// line start. Sync codes are never emitted in the active region, and a line
// start with nothing committed renders black and is counted as an underrun.
// Ports:
//   clk, reset_n      - pixel clock, asynchronous active-low reset
//   wr_valid/ready    - write handshake; a pixel moves when both are high
//   wr_level, wr_last - pixel level and end-of-line marker
//   rd_line_start     - pulse: start rendering the next committed line
//   rd_pixel_advance  - pulse: step to the next pixel
//   rd_level          - level of the current pixel (black when invalid)
//   underrun          - sticky: a line started with no committed bank
//   underrun_count    - saturating underrun count
// ----------------------------------------------------------------------------
module line_pingpong_buffer
  import video_pkg::*;
#(
  parameter int PIXELS_PER_LINE = video_pkg::PIXELS_PER_LINE,
  parameter int LEVEL_W         = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [LEVEL_W-1:0] wr_level,
  input  logic               wr_last,
  input  logic               rd_line_start,
  input  logic               rd_pixel_advance,
  output logic [LEVEL_W-1:0] rd_level,
  output logic               underrun,
  output logic [7:0]         underrun_count
);

  localparam int IDX_W  = $clog2(PIXELS_PER_LINE);
  localparam int LEN_W  = IDX_W + 1;
  localparam int ADDR_W = IDX_W + 1;
  localparam logic [LEVEL_W-1:0] W_BLACK = LEVEL_W'(LEVEL_BLACK);
  localparam logic [LEVEL_W-1:0] W_SYNC  = LEVEL_W'(LEVEL_SYNC);

  bank_state_e        r_bank_state [2];
  bank_state_e        w_bank_state_nxt [2];
  logic [LEN_W-1:0]   r_bank_len [2];

  logic               r_wr_bank;     // bank being (or next to be) filled
  logic [IDX_W-1:0]   r_wr_idx;
  logic               r_rd_next;     // oldest committed bank, next to render
  logic               r_rd_bank;
  logic               r_rd_active;
  logic [LEN_W-1:0]   r_rd_idx;      // saturates at PIXELS_PER_LINE
  logic               r_rd_valid;    // rd data register holds a real pixel
  logic               r_underrun;
  logic [7:0]         r_underrun_count;

  logic               w_wr_ready;
  logic               w_wr_fire;
  logic               w_wr_commit;
  logic [LEVEL_W-1:0] w_wr_data;
  logic               w_swap;
  logic               w_underrun_evt;
  logic               w_rd_bank_nxt;
  logic               w_rd_active_nxt;
  logic [LEN_W-1:0]   w_rd_idx_nxt;
  logic               w_rd_valid_nxt;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [LEVEL_W-1:0] w_ram_q;

  // Banks are filled and rendered in strict alternation, so the write target
  // is the only bank that can be EMPTY/FILLING while the other is busy.
  assign w_wr_ready  = (r_bank_state[r_wr_bank] == BANK_EMPTY) ||
                       (r_bank_state[r_wr_bank] == BANK_FILLING);
  assign w_wr_fire   = wr_valid && w_wr_ready;
  assign w_wr_commit = w_wr_fire &&
                       (wr_last || (r_wr_idx == IDX_W'(PIXELS_PER_LINE - 1)));
  assign w_wr_data   = (wr_level == W_SYNC) ? W_BLACK : wr_level;
  assign w_wr_addr   = {r_wr_bank, r_wr_idx};

  // Only registered state is examined, so a bank committed this cycle is
  // first eligible for a line start on the next cycle.
  assign w_swap         = rd_line_start && (r_bank_state[r_rd_next] == BANK_FULL);
  assign w_underrun_evt = rd_line_start && !w_swap;

  // Bank state machines: next state
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_state_nxt[b] = r_bank_state[b];
      if (rd_line_start && (r_bank_state[b] == BANK_READING)) begin
        w_bank_state_nxt[b] = BANK_EMPTY;
      end
    end
    if (w_swap) begin
      w_bank_state_nxt[r_rd_next] = BANK_READING;
    end
    if (w_wr_fire) begin
      w_bank_state_nxt[r_wr_bank] = w_wr_commit ? BANK_FULL : BANK_FILLING;
    end
  end

  // Read pointer: line start wins over a coincident advance.
  always_comb begin
    w_rd_bank_nxt   = r_rd_bank;
    w_rd_active_nxt = r_rd_active;
    w_rd_idx_nxt    = r_rd_idx;
    if (w_swap) begin
      w_rd_bank_nxt   = r_rd_next;
      w_rd_active_nxt = 1'b1;
      w_rd_idx_nxt    = '0;
    end else if (rd_line_start) begin
      w_rd_active_nxt = 1'b0;
      w_rd_idx_nxt    = '0;
    end else if (rd_pixel_advance && r_rd_active &&
                 (r_rd_idx < LEN_W'(PIXELS_PER_LINE))) begin
      w_rd_idx_nxt = r_rd_idx + 1'b1;
    end
  end

  assign w_rd_valid_nxt = w_rd_active_nxt &&
                          (w_rd_idx_nxt < r_bank_len[w_rd_bank_nxt]);
  assign w_rd_addr      = {w_rd_bank_nxt, w_rd_idx_nxt[IDX_W-1:0]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        r_bank_state[b] <= BANK_EMPTY;
        r_bank_len[b]   <= '0;
      end
      r_wr_bank        <= 1'b0;
      r_wr_idx         <= '0;
      r_rd_next        <= 1'b0;
      r_rd_bank        <= 1'b0;
      r_rd_active      <= 1'b0;
      r_rd_idx         <= '0;
      r_rd_valid       <= 1'b0;
      r_underrun       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_bank_state[b] <= w_bank_state_nxt[b];
      end
      if (w_wr_commit) begin
        r_bank_len[r_wr_bank] <= LEN_W'(r_wr_idx) + 1'b1;
        r_wr_idx              <= '0;
        r_wr_bank             <= ~r_wr_bank;
      end else if (w_wr_fire) begin
        r_wr_idx <= r_wr_idx + 1'b1;
      end
      if (w_swap) begin
        r_rd_next <= ~r_rd_next;
      end
      r_rd_bank   <= w_rd_bank_nxt;
      r_rd_active <= w_rd_active_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      if (w_underrun_evt) begin
        r_underrun <= 1'b1;
        if (r_underrun_count != 8'hFF) begin
          r_underrun_count <= r_underrun_count + 8'd1;
        end
      end
    end
  end

  line_bank_ram #(
    .DEPTH  (2 * PIXELS_PER_LINE),
    .DATA_W (LEVEL_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_fire),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  assign wr_ready       = w_wr_ready;
  assign rd_level       = r_rd_valid ? w_ram_q : W_BLACK;
  assign underrun       = r_underrun;
  assign underrun_count = r_underrun_count;

endmodule
